machine_mem_responder: RTL and testbench

// - Memory-side responder for the Machine step bus. It consumes the 95-bit request Machine_step emits and

---
 rtl/machine_bus_pkg.sv | 41 ++++
 rtl/machine_mem_ram.sv | 39 +++
 rtl/machine_mem_responder.sv | 99 +++++++++
 tb/tb_machine_mem_responder.sv | 155 +++++++++++++++
 4 files changed

// File: rtl/machine_bus_pkg.sv
// Shared encodings for the Machine step bus: request/response tags,
// field offsets within the packed request/response words, and responder FSM states.
package machine_bus_pkg;

  // Request op tags
  localparam logic [1:0] REQ_NONE  = 2'b00;
  localparam logic [1:0] REQ_READ  = 2'b01;
  localparam logic [1:0] REQ_WRITE = 2'b10;
  localparam logic [1:0] REQ_RSVD  = 2'b11;

  // Response tags
  localparam logic [1:0] RESP_IDLE = 2'b00;
  localparam logic [1:0] RESP_READ = 2'b01;
  localparam logic [1:0] RESP_ACK  = 2'b10;
  localparam logic [1:0] RESP_ERR  = 2'b11;

  // Field widths
  localparam int REQ_W  = 95;
  localparam int RESP_W = 65;
  localparam int TAG_W  = 2;
  localparam int DATA_W = 32;
  localparam int STRB_W = 4;
  localparam int CNT_W  = 4;

  // Request field offsets (LSB of each field)
  localparam int REQ_OP_LSB    = 93;
  localparam int REQ_ADDR_LSB  = 61;
  localparam int REQ_WDATA_LSB = 29;
  localparam int REQ_STRB_LSB  = 25;

  // Response field offsets (LSB of each field)
  localparam int RESP_TAG_LSB  = 63;
  localparam int RESP_DATA_LSB = 31;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_e;

endpackage

// File: rtl/machine_mem_ram.sv
// Single-port synchronous word RAM with byte-write enables and a registered
// read port (one cycle read latency). The read register only updates on reads,
// so it holds the last read word until the next read is issued.
module machine_mem_ram
  import machine_bus_pkg::*;
#(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              en,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [STRB_W-1:0] wstrb,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem_q [2**ADDR_W];
  logic [DATA_W-1:0] rdata_q;

  // Byte-masked write or registered read on each enabled cycle.
  // NOTE: the array has no reset branch so it maps onto a RAM macro; contents
  // survive rst. Non-blocking assignments keep every register in this block
  // updating from the same pre-edge values.
  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        for (int i = 0; i < STRB_W; i++) begin
          if (wstrb[i]) mem_q[addr][i*8 +: 8] <= wdata[i*8 +: 8];
        end
      end else begin
        rdata_q <= mem_q[addr];
      end
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/machine_mem_responder.sv
// Memory-side responder for the Machine step bus. Accepts one request at a
// time, performs the RAM access in the acceptance cycle, and presents a single
// one-cycle response LATENCY cycles after acceptance.
module machine_mem_responder
  import machine_bus_pkg::*;
#(
  parameter int ADDR_W  = 10,
  parameter int LATENCY = 2   // 1..15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [REQ_W-1:0]  req,
  output logic              req_ready,
  output logic [RESP_W-1:0] resp
);

  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);

  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [TAG_W-1:0] tag_q;

  logic [TAG_W-1:0]  req_op;
  logic [31:0]       req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic [STRB_W-1:0] req_strb;
  logic              accept;
  logic              req_err;
  logic [TAG_W-1:0]  tag_d;
  logic              ram_en;
  logic              ram_we;
  logic [DATA_W-1:0] ram_rdata;
  logic              unused_rsvd;

  assign req_op    = req[REQ_OP_LSB    +: TAG_W];
  assign req_addr  = req[REQ_ADDR_LSB  +: 32];
  assign req_wdata = req[REQ_WDATA_LSB +: DATA_W];
  assign req_strb  = req[REQ_STRB_LSB  +: STRB_W];
  // Reserved request bits carry no meaning here.
  assign unused_rsvd = ^req[REQ_STRB_LSB-1:0];

  assign req_ready = (state_q == ST_IDLE);
  assign accept    = req_ready && (req_op != REQ_NONE);

  // Misaligned, out-of-range or reserved-op requests never touch the RAM.
  assign req_err = (req_op == REQ_RSVD) || (req_addr[1:0] != 2'b00) ||
                   (req_addr[31:ADDR_W+2] != '0);

  assign tag_d  = req_err                ? RESP_ERR :
                  (req_op == REQ_WRITE)  ? RESP_ACK : RESP_READ;
  assign ram_en = accept && !req_err;
  assign ram_we = (req_op == REQ_WRITE);

  machine_mem_ram #(.ADDR_W(ADDR_W)) u_ram (
    .clk   (clk),
    .en    (ram_en),
    .we    (ram_we),
    .addr  (req_addr[ADDR_W+1:2]),
    .wdata (req_wdata),
    .wstrb (req_strb),
    .rdata (ram_rdata)
  );

  // Transaction FSM: accept in IDLE, count down in WAIT, respond for one cycle in RESP.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      tag_q   <= RESP_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            tag_q   <= tag_d;
            cnt_q   <= CNT_LOAD;
            state_q <= (LATENCY == 1) ? ST_RESP : ST_WAIT;
          end
        end
        ST_WAIT: begin
          cnt_q <= cnt_q - 1'b1;
          if (cnt_q == CNT_W'(1)) state_q <= ST_RESP;
        end
        ST_RESP: state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // Response word is non-zero only in RESP; read data comes from the RAM's held read register.
  always_comb begin
    // NOTE: default first so every path assigns resp and no latch is inferred.
    resp = '0;
    if (state_q == ST_RESP) begin
      resp[RESP_TAG_LSB +: TAG_W] = tag_q;
      if (tag_q == RESP_READ) resp[RESP_DATA_LSB +: DATA_W] = ram_rdata;
    end
  end

endmodule

// File: tb/tb_machine_mem_responder.sv
// Directed, table-driven bench for machine_mem_responder (LATENCY=2 instance)
// plus hand-written sequences for held requests, reset abort and a LATENCY=1 build.
module tb_machine_mem_responder;
  import machine_bus_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [94:0] req, req1;
  logic        req_ready, req_ready1;
  logic [64:0] resp, resp1;

  always #5 clk = ~clk;

  machine_mem_responder #(.ADDR_W(10), .LATENCY(2)) u_dut (
    .clk(clk), .rst(rst), .req(req), .req_ready(req_ready), .resp(resp)
  );

  machine_mem_responder #(.ADDR_W(10), .LATENCY(1)) u_dut1 (
    .clk(clk), .rst(rst), .req(req1), .req_ready(req_ready1), .resp(resp1)
  );

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  strb;
    logic [24:0] rsvd;
    logic [1:0]  tag;
    logic [31:0] rdata;
  } vec_t;

  vec_t vecs[16];

  task automatic check(input string name, input logic [64:0] act, input logic [64:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [94:0] mk_req(input logic [1:0] op, input logic [31:0] addr,
                                         input logic [31:0] wdata, input logic [3:0] strb,
                                         input logic [24:0] rsvd);
    return {op, addr, wdata, strb, rsvd};
  endfunction

  function automatic logic [64:0] mk_resp(input logic [1:0] tag, input logic [31:0] rdata);
    return {tag, rdata, 31'd0};
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // One complete transaction on the LATENCY=2 instance: accept, then check
  // resp at cycles T+1 (zero), T+2 (response) and T+3 (zero).
  task automatic run_vec(input vec_t v, input string name);
    req = mk_req(v.op, v.addr, v.wdata, v.strb, v.rsvd);
    check({name, "_ready"}, {64'd0, req_ready}, 65'd1);
    tick;
    req = '0;
    check({name, "_t1"}, resp, 65'd0);
    tick;
    check({name, "_resp"}, resp, mk_resp(v.tag, v.rdata));
    tick;
    check({name, "_t3"}, resp, 65'd0);
  endtask

  initial begin
    vecs[0]  = '{REQ_WRITE, 32'h0000_0010, 32'hDEAD_BEEF, 4'hF, 25'd0,        RESP_ACK,  32'h0};
    vecs[1]  = '{REQ_READ,  32'h0000_0010, 32'h0,         4'h0, 25'd0,        RESP_READ, 32'hDEAD_BEEF};
    vecs[2]  = '{REQ_WRITE, 32'h0000_0010, 32'h0000_00AA, 4'h1, 25'd0,        RESP_ACK,  32'h0};
    vecs[3]  = '{REQ_READ,  32'h0000_0010, 32'h0,         4'h0, 25'd0,        RESP_READ, 32'hDEAD_BEAA};
    vecs[4]  = '{REQ_WRITE, 32'h0000_0000, 32'h1234_5678, 4'hF, 25'd0,        RESP_ACK,  32'h0};
    vecs[5]  = '{REQ_READ,  32'h0000_0002, 32'h0,         4'h0, 25'd0,        RESP_ERR,  32'h0};
    vecs[6]  = '{REQ_WRITE, 32'h0000_1000, 32'hFFFF_FFFF, 4'hF, 25'd0,        RESP_ERR,  32'h0};
    vecs[7]  = '{REQ_RSVD,  32'h0000_0000, 32'hFFFF_FFFF, 4'hF, 25'd0,        RESP_ERR,  32'h0};
    vecs[8]  = '{REQ_READ,  32'h0000_0000, 32'h0,         4'h0, 25'h1AB_CDEF, RESP_READ, 32'h1234_5678};
    vecs[9]  = '{REQ_WRITE, 32'h0000_0010, 32'hFFFF_FFFF, 4'h0, 25'd0,        RESP_ACK,  32'h0};
    vecs[10] = '{REQ_READ,  32'h0000_0010, 32'h0,         4'h0, 25'd0,        RESP_READ, 32'hDEAD_BEAA};
    vecs[11] = '{REQ_WRITE, 32'h0000_0010, 32'h1122_3344, 4'h6, 25'd0,        RESP_ACK,  32'h0};
    vecs[12] = '{REQ_READ,  32'h0000_0010, 32'h0,         4'h0, 25'd0,        RESP_READ, 32'hDE22_33AA};
    vecs[13] = '{REQ_WRITE, 32'h0000_0FFC, 32'hCAFE_F00D, 4'hF, 25'h1FF_FFFF, RESP_ACK,  32'h0};
    vecs[14] = '{REQ_READ,  32'h0000_0FFC, 32'h0,         4'h0, 25'd0,        RESP_READ, 32'hCAFE_F00D};
    vecs[15] = '{REQ_READ,  32'h0000_0000, 32'h0,         4'h0, 25'd0,        RESP_READ, 32'h1234_5678};

    // Reset state
    rst  = 1'b1;
    req  = '0;
    req1 = '0;
    tick;
    tick;
    check("rst_ready",  {64'd0, req_ready},  65'd1);
    check("rst_resp",   resp,                65'd0);
    check("rst_ready1", {64'd0, req_ready1}, 65'd1);
    check("rst_resp1",  resp1,               65'd0);
    rst = 1'b0;
    tick;

    // Table-driven transactions
    for (int i = 0; i < 16; i++) run_vec(vecs[i], $sformatf("v%0d", i));

    // Read held continuously: one accept every 3 cycles, one response each
    req = mk_req(REQ_READ, 32'h0, 32'h0, 4'h0, 25'd0);
    for (int i = 0; i < 9; i++) begin
      check($sformatf("hold%0d_ready", i), {64'd0, req_ready}, {64'd0, (i % 3 == 0)});
      tick;
      check($sformatf("hold%0d_resp", i), resp,
            (i % 3 == 1) ? mk_resp(RESP_READ, 32'h1234_5678) : 65'd0);
    end
    req = '0;

    // Reset one cycle after accepting a read aborts it
    req = mk_req(REQ_READ, 32'h10, 32'h0, 4'h0, 25'd0);
    check("abort_ready", {64'd0, req_ready}, 65'd1);
    tick;
    req = '0;
    rst = 1'b1;
    tick;
    check("abort_resp0", resp, 65'd0);
    rst = 1'b0;
    for (int i = 1; i < 4; i++) begin
      check($sformatf("abort_ready%0d", i), {64'd0, req_ready}, 65'd1);
      tick;
      check($sformatf("abort_resp%0d", i), resp, 65'd0);
    end
    run_vec(vecs[15], "after_abort");

    // LATENCY=1: write then read same address
    req1 = mk_req(REQ_WRITE, 32'h20, 32'h5A5A_5A5A, 4'hF, 25'd0);
    check("l1_wr_ready", {64'd0, req_ready1}, 65'd1);
    tick;
    req1 = mk_req(REQ_READ, 32'h20, 32'h0, 4'h0, 25'd0);
    check("l1_ack", resp1, mk_resp(RESP_ACK, 32'h0));
    check("l1_busy", {64'd0, req_ready1}, 65'd0);
    tick;
    check("l1_gap_resp", resp1, 65'd0);
    check("l1_rd_ready", {64'd0, req_ready1}, 65'd1);
    tick;
    req1 = '0;
    check("l1_rdata", resp1, mk_resp(RESP_READ, 32'h5A5A_5A5A));
    check("l1_rd_busy", {64'd0, req_ready1}, 65'd0);
    tick;
    check("l1_after", resp1, 65'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
